// File: rtl/pa_ifu_bht_sram_ctrl_pkg.sv
// Shared IFU BHT constants: row/counter geometry, init pattern, controller
// state encoding and the 2-bit saturating counter step.
package pa_ifu_bht_sram_ctrl_pkg;

  localparam int unsigned BHT_ROW_W        = 16;
  localparam int unsigned BHT_CNT_W        = 2;
  localparam int unsigned BHT_ROW_NUM      = 512;
  localparam logic [15:0] BHT_INIT_ROW     = 16'h5555;
  localparam int unsigned BHT_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    BHT_INIT   = 2'b00,
    BHT_READY  = 2'b01,
    BHT_UPD_WR = 2'b10
  } bht_state_e;

  // Saturating step: taken counts up to 3, not-taken counts down to 0.
  function automatic logic [BHT_CNT_W-1:0] bht_cnt_next(
    input logic [BHT_CNT_W-1:0] cnt,
    input logic                 taken
  );
    logic [BHT_CNT_W-1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pa_ifu_bht_sram_ctrl_cnt_upd.sv
// pa_ifu_bht_cnt_upd: combinational counter update for one BHT row.
//   i_row   : 16-bit row read from the BHT SRAM (eight 2-bit counters)
//   i_sel   : counter select within the row
//   i_taken : resolved branch direction
//   o_cnt   : updated counter value
//   o_wen   : active-low bit write enable, only the selected slot enabled
module pa_ifu_bht_cnt_upd
  import pa_ifu_bht_sram_ctrl_pkg::*;
(
  input  logic [15:0] i_row,
  input  logic [2:0]  i_sel,
  input  logic        i_taken,
  output logic [1:0]  o_cnt,
  output logic [15:0] o_wen
);

  logic [1:0] w_old;

  always_comb begin
    w_old = i_row[{i_sel, 1'b0} +: 2];
    o_cnt = bht_cnt_next(w_old, i_taken);
    o_wen = ~(16'h0003 << {i_sel, 1'b0});
  end

endmodule

// File: rtl/pa_ifu_bht_sram_ctrl.sv
// pa_ifu_bht_sram_ctrl: controller in front of the IFU 512x16 BHT SRAM.
// After reset it sweeps every row to INIT_ROW, then serves fetch lookups
// (result one cycle after grant) and drains a single-entry update buffer
// via read-modify-write with bit write enables.
//
// Ports:
//   forever_cpuclk / cpurst_b        clock, async active-low reset
//   ifu_bht_lkup_vld/_idx            lookup request; bht_lkup_gnt accepts
//   bht_lkup_rslt_vld/_rslt          selected counter, cycle after grant
//   ifu_bht_upd_vld/_idx/_taken      update request; bht_upd_rdy accepts
//   bht_init_done                    init sweep complete
//   bht_sram_a/cen/gwen/wen/d        SRAM controls (CEN/GWEN/WEN active-low)
//   bht_sram_q                       SRAM read data, cycle after read
//   ifu_bht_inv_req                  only with PA_IFU_BHT_INV_EN: re-run sweep
module pa_ifu_bht_sram_ctrl
  import pa_ifu_bht_sram_ctrl_pkg::*;
#(
  parameter int unsigned IDX_WIDTH    = 12,
  parameter int unsigned ROW_NUM      = BHT_ROW_NUM,
  parameter logic [15:0] INIT_ROW     = BHT_INIT_ROW,
  parameter int unsigned STARVE_LIMIT = BHT_STARVE_LIMIT
)(
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
`ifdef PA_IFU_BHT_INV_EN
  input  logic                 ifu_bht_inv_req,
`endif
  input  logic                 ifu_bht_lkup_vld,
  input  logic [IDX_WIDTH-1:0] ifu_bht_lkup_idx,
  output logic                 bht_lkup_gnt,
  output logic                 bht_lkup_rslt_vld,
  output logic [1:0]           bht_lkup_rslt,
  input  logic                 ifu_bht_upd_vld,
  input  logic [IDX_WIDTH-1:0] ifu_bht_upd_idx,
  input  logic                 ifu_bht_upd_taken,
  output logic                 bht_upd_rdy,
  output logic                 bht_init_done,
  output logic [IDX_WIDTH-4:0] bht_sram_a,
  output logic                 bht_sram_cen,
  output logic                 bht_sram_gwen,
  output logic [15:0]          bht_sram_wen,
  output logic [15:0]          bht_sram_d,
  input  logic [15:0]          bht_sram_q
);

  localparam int unsigned ROW_W = IDX_WIDTH - 3;
  localparam int unsigned SWP_W = $clog2(ROW_NUM);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  bht_state_e            r_state;
  logic [SWP_W-1:0]      r_sweep_cnt;
  logic                  r_buf_vld;
  logic [IDX_WIDTH-1:0]  r_buf_idx;
  logic                  r_buf_taken;
  logic [STV_W-1:0]      r_starve;
  logic                  r_init_done;
  logic                  r_rslt_vld;
  logic [2:0]            r_sel;

  logic                  w_inv;
  logic                  w_starved;
  logic                  w_drain;
  logic                  w_gnt;
  logic                  w_upd_rdy;
  logic                  w_upd_acc;
  logic [1:0]            w_new_cnt;
  logic [15:0]           w_upd_wen;

`ifdef PA_IFU_BHT_INV_EN
  // Acted on at the same edge it is seen, so no separate pending flag.
  assign w_inv = ifu_bht_inv_req;
`else
  assign w_inv = 1'b0;
`endif

  always_comb begin
    w_starved = (r_starve == STV_W'(STARVE_LIMIT));
    w_drain   = (r_state == BHT_READY) & ~w_inv & r_buf_vld &
                (~ifu_bht_lkup_vld | w_starved);
    w_gnt     = (r_state == BHT_READY) & ~w_inv & ifu_bht_lkup_vld &
                ~(r_buf_vld & w_starved);
    w_upd_rdy = r_init_done & ~r_buf_vld;
    w_upd_acc = ifu_bht_upd_vld & w_upd_rdy;
  end

  pa_ifu_bht_cnt_upd u_cnt_upd (
    .i_row   (bht_sram_q),
    .i_sel   (r_buf_idx[2:0]),
    .i_taken (r_buf_taken),
    .o_cnt   (w_new_cnt),
    .o_wen   (w_upd_wen)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= BHT_INIT;
      r_sweep_cnt <= '0;
      r_buf_vld   <= 1'b0;
      r_buf_idx   <= '0;
      r_buf_taken <= 1'b0;
      r_starve    <= '0;
      r_init_done <= 1'b0;
      r_rslt_vld  <= 1'b0;
      r_sel       <= '0;
    end else begin
      r_rslt_vld <= w_gnt;
      if (w_gnt) r_sel <= ifu_bht_lkup_idx[2:0];

      if (w_upd_acc) begin
        r_buf_vld   <= 1'b1;
        r_buf_idx   <= ifu_bht_upd_idx;
        r_buf_taken <= ifu_bht_upd_taken;
      end

      case (r_state)
        BHT_INIT: begin
          if (r_sweep_cnt == SWP_W'(ROW_NUM - 1)) begin
            r_sweep_cnt <= '0;
            r_state     <= BHT_READY;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
          end
        end
        BHT_READY: begin
          r_init_done <= 1'b1;
          if (w_drain) begin
            r_starve <= '0;
            r_state  <= BHT_UPD_WR;
          end else if (w_gnt && r_buf_vld && !w_starved) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        BHT_UPD_WR: begin
          r_buf_vld <= 1'b0;
          r_state   <= BHT_READY;
        end
        default: r_state <= BHT_INIT;
      endcase

      // Invalidate overrides everything above: buffer dropped, sweep restarts.
      if (w_inv && (r_state != BHT_INIT)) begin
        r_state     <= BHT_INIT;
        r_sweep_cnt <= '0;
        r_buf_vld   <= 1'b0;
        r_starve    <= '0;
        r_init_done <= 1'b0;
      end
    end
  end

  // SRAM controls are decoded from state so a grant reads in the same cycle;
  // held inactive while reset is asserted.
  always_comb begin
    bht_sram_a    = '0;
    bht_sram_cen  = 1'b1;
    bht_sram_gwen = 1'b1;
    bht_sram_wen  = '1;
    bht_sram_d    = '0;
    if (cpurst_b) begin
      case (r_state)
        BHT_INIT: begin
          bht_sram_a    = ROW_W'(r_sweep_cnt);
          bht_sram_cen  = 1'b0;
          bht_sram_gwen = 1'b0;
          bht_sram_wen  = '0;
          bht_sram_d    = INIT_ROW;
        end
        BHT_READY: begin
          if (w_drain) begin
            bht_sram_a   = r_buf_idx[IDX_WIDTH-1:3];
            bht_sram_cen = 1'b0;
          end else if (w_gnt) begin
            bht_sram_a   = ifu_bht_lkup_idx[IDX_WIDTH-1:3];
            bht_sram_cen = 1'b0;
          end
        end
        BHT_UPD_WR: begin
          bht_sram_a    = r_buf_idx[IDX_WIDTH-1:3];
          bht_sram_cen  = 1'b0;
          bht_sram_gwen = 1'b0;
          bht_sram_wen  = w_upd_wen;
          bht_sram_d    = {8{w_new_cnt}};
        end
        default: ;
      endcase
    end
  end

  assign bht_lkup_gnt      = w_gnt;
  assign bht_lkup_rslt_vld = r_rslt_vld;
  assign bht_lkup_rslt     = r_rslt_vld ? bht_sram_q[{r_sel, 1'b0} +: 2] : 2'b00;
  assign bht_upd_rdy       = w_upd_rdy;
  assign bht_init_done     = r_init_done;

endmodule

// File: tb/tb_pa_ifu_bht_sram_ctrl.sv
module tb_pa_ifu_bht_sram_ctrl;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        inv_req;
  logic        lkup_vld;
  logic [11:0] lkup_idx;
  logic        lkup_gnt;
  logic        rslt_vld;
  logic [1:0]  rslt;
  logic        upd_vld;
  logic [11:0] upd_idx;
  logic        upd_taken;
  logic        upd_rdy;
  logic        init_done;
  logic [8:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [15:0] sram_wen;
  logic [15:0] sram_d;
  logic [15:0] sram_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  mdl [4096];
  logic [1:0]  exp_q [$];
  logic [15:0] mem [512];

  always #5 clk = ~clk;

  pa_ifu_bht_sram_ctrl dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (cpurst_b),
`ifdef PA_IFU_BHT_INV_EN
    .ifu_bht_inv_req   (inv_req),
`endif
    .ifu_bht_lkup_vld  (lkup_vld),
    .ifu_bht_lkup_idx  (lkup_idx),
    .bht_lkup_gnt      (lkup_gnt),
    .bht_lkup_rslt_vld (rslt_vld),
    .bht_lkup_rslt     (rslt),
    .ifu_bht_upd_vld   (upd_vld),
    .ifu_bht_upd_idx   (upd_idx),
    .ifu_bht_upd_taken (upd_taken),
    .bht_upd_rdy       (upd_rdy),
    .bht_init_done     (init_done),
    .bht_sram_a        (sram_a),
    .bht_sram_cen      (sram_cen),
    .bht_sram_gwen     (sram_gwen),
    .bht_sram_wen      (sram_wen),
    .bht_sram_d        (sram_d),
    .bht_sram_q        (sram_q)
  );

  // Behavioural single-port SRAM with active-low bit write enables.
  always @(posedge clk) begin
    if (sram_cen === 1'b0) begin
      if (sram_gwen === 1'b0)
        mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else
        sram_q <= mem[sram_a];
    end
  end

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 4096; i++) mdl[i] = 2'b01;
  endtask

  // Checks a full 512-row sweep starting at the next negedge, then the
  // init_done timing. Ends in the drive phase (posedge + 1).
  task automatic check_sweep(input string nm);
    int bad = 0;
    int first = -1;
    logic [8:0] fa = '0;
    logic [15:0] fw = '0;
    for (int unsigned i = 0; i < 512; i++) begin
      @(negedge clk);
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 16'h0000 ||
          sram_d !== 16'h5555 || sram_a !== 9'(i) || init_done !== 1'b0 ||
          upd_rdy !== 1'b0 || lkup_gnt !== 1'b0) begin
        if (bad == 0) begin first = int'(i); fa = sram_a; fw = sram_wen; end
        bad++;
      end
      if (i == 511) begin lkup_vld = 1'b0; upd_vld = 1'b0; end
      @(posedge clk);
    end
    #1;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_sweep: %0d bad cycles, first row %0d a=%0d wen=%h, required 0 bad", nm, bad, first, fa, fw);
    end
    @(negedge clk);
    n_tests++;
    if (init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_512: init_done=%b required 0", nm, init_done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (init_done !== 1'b1 || upd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_513: init_done=%b upd_rdy=%b required 1 1", nm, init_done, upd_rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_pop(input string nm);
    logic [1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_rslt: result %b with empty scoreboard, required none", nm, rslt);
    end else begin
      e = exp_q.pop_front();
      if (rslt !== e) begin
        n_fail++;
        $display("FAIL %s_rslt: rslt=%b required %b", nm, rslt, e);
      end
    end
  endtask

  task automatic do_lookup(input logic [11:0] idx, input string nm);
    int unsigned w = 0;
    logic g = 1'b0;
    lkup_vld = 1'b1;
    lkup_idx = idx;
    while (!g && w < 20) begin
      @(negedge clk);
      g = lkup_gnt;
      if (g) exp_q.push_back(mdl[idx]);
      @(posedge clk); #1;
      w++;
    end
    lkup_vld = 1'b0;
    n_tests++;
    if (!g) begin
      n_fail++;
      $display("FAIL %s_gnt: no grant in 20 cycles, required grant", nm);
    end else begin
      @(negedge clk);
      n_tests++;
      if (rslt_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_vld: rslt_vld=%b required 1", nm, rslt_vld);
      end
      check_pop(nm);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_update(input logic [11:0] idx, input logic t, input string nm);
    int unsigned w = 0;
    logic acc = 1'b0;
    upd_vld = 1'b1; upd_idx = idx; upd_taken = t;
    while (!acc && w < 20) begin
      @(negedge clk);
      acc = upd_rdy;
      @(posedge clk); #1;
      w++;
    end
    upd_vld = 1'b0;
    if (acc) mdl[idx] = sat(mdl[idx], t);
    acc = 1'b0; w = 0;
    while (!acc && w < 20) begin
      @(negedge clk);
      acc = upd_rdy;
      @(posedge clk); #1;
      w++;
    end
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL %s_upd: update not drained in 20 cycles, required upd_rdy=1", nm);
    end
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0; inv_req = 1'b0;
    lkup_vld = 1'b1; lkup_idx = 12'hFFF;
    upd_vld = 1'b1; upd_idx = 12'h000; upd_taken = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 16'hFFFF ||
        init_done !== 1'b0 || rslt_vld !== 1'b0 || rslt !== 2'b00 ||
        upd_rdy !== 1'b0 || lkup_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: cen=%b gwen=%b wen=%h done=%b rv=%b r=%b rdy=%b gnt=%b required 1 1 ffff 0 0 00 0 0",
               sram_cen, sram_gwen, sram_wen, init_done, rslt_vld, rslt, upd_rdy, lkup_gnt);
    end
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    check_sweep("init");
    mdl_reset();
    do_lookup(12'hFFF, "lkup_fff");
  endtask

  task automatic test_upd_rmw();
    upd_vld = 1'b1; upd_idx = 12'h013; upd_taken = 1'b1;
    @(negedge clk);
    n_tests++;
    if (upd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rmw_acc: upd_rdy=%b required 1", upd_rdy);
    end
    @(posedge clk); #1;
    upd_vld = 1'b0;
    mdl[12'h013] = sat(mdl[12'h013], 1'b1);
    @(negedge clk);
    n_tests++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_a !== 9'd2 || upd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_rd: cen=%b gwen=%b a=%0d rdy=%b required 0 1 2 0", sram_cen, sram_gwen, sram_a, upd_rdy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== 9'd2 ||
        sram_wen !== 16'hFF3F || sram_d !== 16'hAAAA || upd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_wr: cen=%b gwen=%b a=%0d wen=%h d=%h rdy=%b required 0 0 2 ff3f aaaa 0",
               sram_cen, sram_gwen, sram_a, sram_wen, sram_d, upd_rdy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (upd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rmw_rdy_back: upd_rdy=%b required 1", upd_rdy);
    end
    @(posedge clk); #1;
    do_lookup(12'h013, "rmw_lkup");
  endtask

  task automatic test_saturate();
    for (int unsigned k = 0; k < 3; k++) do_update(12'h020, 1'b1, "sat_up");
    do_lookup(12'h020, "sat_hi");
    for (int unsigned k = 0; k < 4; k++) do_update(12'h020, 1'b0, "sat_dn");
    do_lookup(12'h020, "sat_lo");
    do_lookup(12'h021, "sat_nb1");
    do_lookup(12'h027, "sat_nb7");
  endtask

  task automatic test_starve();
    logic prev_g = 1'b0;
    logic exp_g;
    lkup_vld = 1'b1; lkup_idx = 12'h100;
    upd_vld = 1'b1; upd_idx = 12'h040; upd_taken = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_g = (k <= 4) || (k == 7);
      if (k == 0) begin
        n_tests++;
        if (upd_rdy !== 1'b1) begin
          n_fail++; $display("FAIL starve_acc: upd_rdy=%b required 1", upd_rdy);
        end
      end
      n_tests++;
      if (lkup_gnt !== exp_g) begin
        n_fail++; $display("FAIL starve_gnt_%0d: gnt=%b required %b", k, lkup_gnt, exp_g);
      end
      n_tests++;
      if (rslt_vld !== prev_g) begin
        n_fail++; $display("FAIL starve_rv_%0d: rslt_vld=%b required %b", k, rslt_vld, prev_g);
      end
      if (rslt_vld === 1'b1) check_pop("starve");
      if (k == 5) begin
        n_tests++;
        if (sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_a !== 9'd8) begin
          n_fail++;
          $display("FAIL starve_drain_rd: cen=%b gwen=%b a=%0d required 0 1 8", sram_cen, sram_gwen, sram_a);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== 9'd8 || sram_wen !== 16'hFFFC) begin
          n_fail++;
          $display("FAIL starve_upd_wr: cen=%b gwen=%b a=%0d wen=%h required 0 0 8 fffc", sram_cen, sram_gwen, sram_a, sram_wen);
        end
      end
      if (lkup_gnt === 1'b1) exp_q.push_back(mdl[12'h100]);
      prev_g = lkup_gnt;
      @(posedge clk); #1;
      if (k == 0) begin
        upd_vld = 1'b0;
        mdl[12'h040] = sat(mdl[12'h040], 1'b1);
      end
    end
    lkup_vld = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rslt_vld !== 1'b1) begin
      n_fail++; $display("FAIL starve_last_vld: rslt_vld=%b required 1", rslt_vld);
    end
    if (rslt_vld === 1'b1) check_pop("starve_last");
    @(posedge clk); #1;
    do_lookup(12'h040, "starve_upd");
  endtask

  task automatic test_reset_mid();
    upd_vld = 1'b1; upd_idx = 12'h080; upd_taken = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    upd_vld = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (sram_gwen !== 1'b0 || sram_a !== 9'd16) begin
      n_fail++; $display("FAIL rstmid_in_upd: gwen=%b a=%0d required 0 16", sram_gwen, sram_a);
    end
    cpurst_b = 1'b0;
    #1;
    n_tests++;
    if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 16'hFFFF ||
        upd_rdy !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: cen=%b gwen=%b wen=%h rdy=%b done=%b required 1 1 ffff 0 0",
               sram_cen, sram_gwen, sram_wen, upd_rdy, init_done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    mdl_reset();
    check_sweep("rstmid");
    do_lookup(12'h080, "rstmid_lost");
    do_lookup(12'h013, "rstmid_swept");
  endtask

`ifdef PA_IFU_BHT_INV_EN
  task automatic test_inv();
    upd_vld = 1'b1; upd_idx = 12'h200; upd_taken = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    upd_vld = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    inv_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== 9'd64) begin
      n_fail++; $display("FAIL inv_wr: cen=%b gwen=%b a=%0d required 0 0 64", sram_cen, sram_gwen, sram_a);
    end
    @(posedge clk); #1;
    inv_req = 1'b0;
    mdl_reset();
    check_sweep("inv");
    do_lookup(12'h200, "inv_lkup");
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_upd_rmw();
    test_saturate();
    test_starve();
    test_reset_mid();
`ifdef PA_IFU_BHT_INV_EN
    test_inv();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
